four_ask_demod: RTL and testbench

- Downstream consumer of the 4-ASK modulator output. Recovers 2-bit symbols from the PWM-encoded `modulated` line by measuring each carrier pulse's high time.
- Carrier high times are 22/47/82/115 clk over a 500-clk period.
- Emits symbols in parallel, plus a re-serialized MSB-first bit stream that matches the modulator's serial `message` input for loopback checking.
- Sits at the receive side of the board loopback path, in the same clk domain as the modulator.

---
 rtl/four_ask_pkg.sv | 31 +++
 rtl/four_ask_demod_if.sv | 17 +
 rtl/ask_pulse_meter.sv | 72 +++++++
 rtl/four_ask_demod.sv | 120 ++++++++++++
 tb/tb_four_ask_demod.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/four_ask_pkg.sv
// Shared 4-ASK constants and types: the modulator's DC table and the demodulator's
// thresholds are both derived from here so the two ends cannot drift apart.
package four_ask_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEASURE,
    CLASSIFY
  } state_t;

  localparam int DEF_PERIOD         = 500;
  localparam int DEF_TH1            = 34;
  localparam int DEF_TH2            = 64;
  localparam int DEF_TH3            = 98;
  localparam int DEF_MAX_W          = 200;
  localparam int DEF_PULSES_PER_SYM = 4;
  localparam int DEF_CW             = 10;

  // Carrier high time per symbol, indexed by symbol value.
  localparam int HIGH_TIME [4] = '{22, 47, 82, 115};

  function automatic sym_t classify(input int w, input int th1, input int th2, input int th3);
    if (w < th1) return 2'b00;
    if (w < th2) return 2'b01;
    if (w < th3) return 2'b10;
    return 2'b11;
  endfunction

endpackage

// File: rtl/four_ask_demod_if.sv
// Receive-side bundle: the PWM line in, recovered symbols/bits and carrier lock out.
interface four_ask_demod_if;
  import four_ask_pkg::*;

  logic modulated;
  sym_t sym;
  logic sym_valid;
  logic sym_err;
  logic bit_out;
  logic bit_valid;
  logic lock;

  modport master (output modulated,
                  input  sym, sym_valid, sym_err, bit_out, bit_valid, lock);
  modport slave  (input  modulated,
                  output sym, sym_valid, sym_err, bit_out, bit_valid, lock);
endinterface

// File: rtl/ask_pulse_meter.sv
// Measures each carrier pulse's high time and flags loss of carrier.
// width_valid is high for the single CLASSIFY cycle that follows a falling edge.
module ask_pulse_meter
  import four_ask_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          modulated,
  output logic [CW-1:0] width,
  output logic          width_valid,
  output logic          timeout
);

  localparam logic [CW-1:0] TO_LAST = CW'(2 * PERIOD - 1);
  localparam logic [CW-1:0] W_SAT   = CW'(MAX_W + 1);

  state_t        state, state_nx;
  logic          mod_q;
  logic          armed;
  logic [CW-1:0] to_cnt;
  logic          rise, fall;

  // armed blocks a line that was already high when reset released from counting as a rise.
  assign rise = modulated & ~mod_q & armed;
  assign fall = ~modulated & mod_q;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx    = state;
    width_valid = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      WAIT_RISE: begin
        if (rise) state_nx = MEASURE;
        else if (to_cnt == TO_LAST) timeout = 1'b1;
      end
      MEASURE:  if (fall) state_nx = CLASSIFY;
      CLASSIFY: begin
        width_valid = 1'b1;
        state_nx    = rise ? MEASURE : WAIT_RISE;
      end
      default:  state_nx = WAIT_RISE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT_RISE;
      mod_q  <= 1'b0;
      armed  <= 1'b0;
      width  <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      mod_q <= modulated;
      armed <= armed | ~modulated;
      if (rise) begin
        width  <= CW'(1);
        to_cnt <= '0;
      end else begin
        if (state == MEASURE && modulated && width != W_SAT) width <= width + CW'(1);
        if (state == WAIT_RISE && to_cnt != TO_LAST) to_cnt <= to_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/four_ask_demod.sv
// 4-ASK receiver: classifies pulse widths, votes over a window of pulses per symbol,
// and re-serializes each symbol MSB first for loopback comparison.
module four_ask_demod
  import four_ask_pkg::*;
#(
  parameter int PERIOD         = DEF_PERIOD,
  parameter int TH1            = DEF_TH1,
  parameter int TH2            = DEF_TH2,
  parameter int TH3            = DEF_TH3,
  parameter int MAX_W          = DEF_MAX_W,
  parameter int PULSES_PER_SYM = DEF_PULSES_PER_SYM,
  parameter int CW             = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  four_ask_demod_if.slave  bus
);

  localparam int PW = $clog2(PULSES_PER_SYM + 1);

  logic [CW-1:0] width;
  logic          width_valid, timeout;

  ask_pulse_meter #(.PERIOD(PERIOD), .MAX_W(MAX_W), .CW(CW)) u_meter (
    .clk        (clk),
    .rst        (rst),
    .modulated  (bus.modulated),
    .width      (width),
    .width_valid(width_valid),
    .timeout    (timeout)
  );

  sym_t          cls, ref_class, ref_nx, pend_sym, sym;
  logic [PW-1:0] pcnt;
  logic          have_ref, err, err_nx, pulse_ok, last;
  logic          pend_err, close;
  logic          lock, sym_valid, sym_err, bit_out, bit_valid, lsb_pend;

  // ref/err as they stand once the current pulse is folded in.
  always_comb begin
    cls      = classify(int'(width), TH1, TH2, TH3);
    pulse_ok = int'(width) <= MAX_W;
    ref_nx   = (pulse_ok && !have_ref) ? cls : ref_class;
    err_nx   = err | ~pulse_ok | (pulse_ok & have_ref & (cls != ref_class));
    last     = (pcnt == PW'(PULSES_PER_SYM - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock      <= 1'b0;
      pcnt      <= '0;
      err       <= 1'b0;
      have_ref  <= 1'b0;
      ref_class <= '0;
      pend_sym  <= '0;
      pend_err  <= 1'b0;
      close     <= 1'b0;
    end else begin
      close <= 1'b0;
      if (timeout) begin
        lock      <= 1'b0;
        pcnt      <= '0;
        err       <= 1'b0;
        have_ref  <= 1'b0;
        ref_class <= '0;
      end else if (width_valid) begin
        if (pulse_ok) lock <= 1'b1;
        if (last) begin
          pend_sym  <= ref_nx;
          pend_err  <= err_nx;
          close     <= 1'b1;
          pcnt      <= '0;
          err       <= 1'b0;
          have_ref  <= 1'b0;
          ref_class <= '0;
        end else begin
          pcnt      <= pcnt + PW'(1);
          err       <= err_nx;
          ref_class <= ref_nx;
          have_ref  <= have_ref | pulse_ok;
        end
      end
    end
  end

  // Symbol strobe one cycle after the window closes; bits follow on the next two cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym       <= '0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      lsb_pend  <= 1'b0;
    end else begin
      sym_valid <= close;
      sym_err   <= close & pend_err;
      if (close) sym <= pend_sym;
      if (sym_valid) begin
        bit_out   <= sym[1];
        bit_valid <= 1'b1;
        lsb_pend  <= 1'b1;
      end else if (lsb_pend) begin
        bit_out   <= sym[0];
        bit_valid <= 1'b1;
        lsb_pend  <= 1'b0;
      end else begin
        bit_valid <= 1'b0;
      end
    end
  end

  assign bus.sym       = sym;
  assign bus.sym_valid = sym_valid;
  assign bus.sym_err   = sym_err;
  assign bus.bit_out   = bit_out;
  assign bus.bit_valid = bit_valid;
  assign bus.lock      = lock;

endmodule

// File: tb/tb_four_ask_demod.sv
// Directed and randomized pulse trains checked against a window-voting reference model.
module tb_four_ask_demod;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  four_ask_demod_if bus ();

  four_ask_demod dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = 0;

  typedef struct {
    logic [1:0] s;
    logic       e;
    int         c;
  } sym_ev_t;

  sym_ev_t ev_mon;
  sym_ev_t sym_q[$];
  logic    bit_q[$];
  int      bit_cyc_q[$];
  logic    rx_bits[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sym_valid) begin
      ev_mon.s = bus.sym;
      ev_mon.e = bus.sym_err;
      ev_mon.c = cyc;
      sym_q.push_back(ev_mon);
    end
    if (bus.bit_valid) begin
      bit_q.push_back(bus.bit_out);
      bit_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: class by threshold bands; a window reports the first valid class and
  // flags an error if any pulse is out of range or any valid class disagrees.
  function automatic logic [1:0] model_class(input int w);
    if (w < 34) return 2'd0;
    if (w < 64) return 2'd1;
    if (w < 98) return 2'd2;
    return 2'd3;
  endfunction

  function automatic void model_window(input int w0, input int w1, input int w2, input int w3,
                                       output logic [1:0] s, output logic e);
    int   ws[4];
    logic [1:0] classes[$];
    int   n_bad;
    ws    = '{w0, w1, w2, w3};
    n_bad = 0;
    foreach (ws[i]) begin
      if (ws[i] > 200) n_bad++;
      else classes.push_back(model_class(ws[i]));
    end
    s = (classes.size() > 0) ? classes[0] : 2'd0;
    e = (n_bad > 0);
    foreach (classes[i]) if (classes[i] != s) e = 1'b1;
  endfunction

  // Called at a negedge; drives w high cycles then lo low cycles.
  task automatic pulse(input int w, input int lo);
    bus.modulated = 1'b1;
    repeat (w) @(negedge clk);
    bus.modulated = 1'b0;
    last_fall = cyc + 1;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_window(input int w0, input int w1, input int w2, input int w3);
    pulse(w0, 500 - w0);
    pulse(w1, 500 - w1);
    pulse(w2, 500 - w2);
    pulse(w3, 500 - w3);
  endtask

  task automatic verify_window(input string tag, input logic [1:0] es, input logic ee);
    sym_ev_t ev;
    logic    b;
    int      c;
    check({tag, " n_sym"}, sym_q.size(), 1);
    if (sym_q.size() > 0) begin
      ev = sym_q.pop_front();
      check({tag, " sym"}, ev.s, es);
      check({tag, " sym_err"}, ev.e, ee);
      check({tag, " sym_cycle"}, ev.c, last_fall + 2);
    end
    check({tag, " n_bits"}, bit_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (bit_q.size() > 0) begin
        b = bit_q.pop_front();
        c = bit_cyc_q.pop_front();
        check($sformatf("%s bit%0d", tag, i), b, es[1-i]);
        check($sformatf("%s bit%0d_cycle", tag, i), c, last_fall + 3 + i);
        rx_bits.push_back(b);
      end
    end
    sym_q.delete();
    bit_q.delete();
    bit_cyc_q.delete();
  endtask

  initial begin
    int         nom[4];
    int         bw[6];
    logic [1:0] bcls[6];
    logic [1:0] ms;
    logic       me;
    int         w[4];
    logic       msg[4];

    nom  = four_ask_pkg::HIGH_TIME;
    bw   = '{33, 34, 63, 64, 97, 98};
    bcls = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    msg  = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with the line held high; release must not count it as a rise.
    rst = 1'b1;
    bus.modulated = 1'b1;
    repeat (5) @(negedge clk);
    check("reset outputs",
          {30'd0, bus.sym} | {bus.sym_valid, bus.sym_err, bus.bit_out, bus.bit_valid, bus.lock, 27'd0},
          32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("high after reset no sym", sym_q.size(), 0);
    check("high after reset lock", bus.lock, 0);
    bus.modulated = 1'b0;
    repeat (50) @(negedge clk);
    check("first fall no lock", bus.lock, 0);
    check("first fall no sym", sym_q.size(), 0);

    // Nominal 01 window, lock after the first pulse.
    pulse(47, 453);
    check("lock after first pulse", bus.lock, 1);
    pulse(47, 453);
    pulse(47, 453);
    pulse(47, 453);
    verify_window("nominal 47", 2'b01, 1'b0);

    // Threshold boundaries.
    foreach (bw[i]) begin
      send_window(bw[i], bw[i], bw[i], bw[i]);
      verify_window($sformatf("boundary %0d", bw[i]), bcls[i], 1'b0);
    end

    // Invalid and disagreeing windows.
    send_window(201, 201, 201, 201);
    verify_window("all invalid", 2'b00, 1'b1);
    send_window(22, 201, 22, 22);
    verify_window("one invalid", 2'b00, 1'b1);
    send_window(115, 115, 82, 115);
    verify_window("disagree", 2'b11, 1'b1);

    // Randomized windows against the reference model.
    for (int k = 0; k < 8; k++) begin
      ms = 2'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) w[j] = nom[ms];
      if ($urandom_range(0, 2) == 0) w[$urandom_range(0, 3)] = int'($urandom_range(1, 240));
      model_window(w[0], w[1], w[2], w[3], ms, me);
      send_window(w[0], w[1], w[2], w[3]);
      verify_window($sformatf("random %0d", k), ms, me);
    end

    // Loss of carrier mid-window discards the partial window.
    pulse(115, 385);
    pulse(115, 990);
    check("lock held before timeout", bus.lock, 1);
    repeat (20) @(negedge clk);
    check("lock dropped after timeout", bus.lock, 0);
    check("timeout no sym", sym_q.size(), 0);
    send_window(22, 22, 22, 22);
    verify_window("after timeout", 2'b00, 1'b0);
    check("relock", bus.lock, 1);

    // Loopback: message bits pair up into symbols sent with the modulator's widths.
    rx_bits.delete();
    for (int k = 0; k < 2; k++) begin
      ms = {msg[2*k], msg[2*k+1]};
      send_window(nom[ms], nom[ms], nom[ms], nom[ms]);
      verify_window($sformatf("loopback %0d", k), ms, 1'b0);
    end
    check("loopback n_bits", rx_bits.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_bits.size()) check($sformatf("loopback bit%0d", i), rx_bits[i], msg[i]);

    // Async reset in the middle of a pulse.
    bus.modulated = 1'b1;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset lock", bus.lock, 0);
    check("async reset sym", bus.sym, 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    bus.modulated = 1'b0;
    repeat (400) @(negedge clk);
    check("post reset high not measured", bus.lock, 0);
    check("post reset no sym", sym_q.size(), 0);
    send_window(82, 82, 82, 82);
    verify_window("post reset", 2'b10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
